imem_load_fetch_ctrl: RTL and testbench



---
 rtl/imem_load_fetch_ctrl.sv | 107 ++++++++++
 tb/tb_imem_load_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: owns the single instruction-memory port, time-sharing it
// between a byte-stream boot loader and the core's PC/fetch sequencer.
//   load_start/byte_in/byte_valid/byte_ready/load_done : program-load interface
//   run_en/branch_taken/branch_target/pc/instr/instr_valid : core front end
//   mem_we/mem_a/mem_wd/mem_rd : instruction memory port (combinational read)
module imem_load_fetch_ctrl #(
    parameter int AW         = 4,
    parameter int LOAD_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        load_done,
    input  logic        run_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;
    localparam logic [AW:0] LAST = (AW+1)'(LOAD_WORDS);
    state_t      state, state_n;
    logic [1:0]  bcnt;
    logic [AW:0] wcnt;
    logic [AW-1:0] waddr;
    logic [31:0] buffer;
    logic        done_q;
    logic        take;
    logic        last_word;
    logic [31:0] load_a;
    assign take      = byte_valid & byte_ready;
    assign last_word = (wcnt + 1'b1) == LAST;
    assign load_a    = {{(30-AW){1'b0}}, waddr, 2'b00};
    assign mem_wd    = buffer;
    assign instr     = mem_rd;
    assign load_done = done_q;
    always_comb begin
        state_n     = state;
        byte_ready  = 1'b0;
        instr_valid = 1'b0;
        mem_we      = 1'b0;
        mem_a       = pc;
        case (state)
            IDLE:  state_n = load_start ? LOAD : run_en ? RUN : IDLE;
            LOAD: begin
                byte_ready = 1'b1;
                mem_a      = load_a;
                state_n    = (!load_start && take && bcnt == 2'd3) ? WRITE : LOAD;
            end
            WRITE: begin
                // the write still lands on a restart; only reset suppresses it
                mem_we  = !rst;
                mem_a   = load_a;
                state_n = (load_start || !last_word) ? LOAD : IDLE;
            end
            RUN: begin
                instr_valid = run_en;
                state_n     = load_start ? LOAD : RUN;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            bcnt   <= '0;
            wcnt   <= '0;
            waddr  <= '0;
            buffer <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= (state == WRITE) && !load_start && last_word;
            if (load_start) begin
                // every load_start lands in LOAD with a fresh session
                pc     <= '0;
                bcnt   <= '0;
                wcnt   <= '0;
                waddr  <= '0;
                buffer <= '0;
            end else begin
                case (state)
                    LOAD: if (take) begin
                        buffer[8*bcnt +: 8] <= byte_in;
                        bcnt                <= bcnt + 2'd1;
                    end
                    WRITE: begin
                        waddr <= waddr + 1'b1;
                        wcnt  <= wcnt + 1'b1;
                        if (last_word) pc <= '0;
                    end
                    RUN: if (run_en) pc <= branch_taken ? (branch_target & ~32'd3) : pc + 32'd4;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: randomized self-checking bench with a behavioural memory and PC model.
module tb_imem_load_fetch_ctrl;
    localparam int AW = 4;
    localparam int LW = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        run_en = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        byte_ready, load_done, instr_valid, mem_we;
    logic [31:0] pc, instr, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [16];
    int n_checks = 0;
    int n_fail = 0;

    imem_load_fetch_ctrl #(.AW(AW), .LOAD_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .load_done(load_done),
        .run_en(run_en), .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .instr(instr), .instr_valid(instr_valid), .mem_we(mem_we),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    assign mem_rd = mem[mem_a[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({byte_ready, load_done, instr_valid, mem_we, pc, mem_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: br/ld/iv/we=%b%b%b%b pc=%h a=%h required all 0",
                     byte_ready, load_done, instr_valid, mem_we, pc, mem_a);
        end
    endtask

    // mode 0: byte every cycle, 1: every other cycle, 2: random valid
    task automatic test_load(input logic [7:0] b[8], input int mode, input string tag);
        int i, wr, done_c;
        int acc[8];
        int wc[2];
        logic [31:0] wa[2], wd[2], w;
        logic br_done;
        i = 0; wr = 0; done_c = -1; br_done = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b1; byte_valid = 1'b0; run_en = 1'b0; branch_taken = 1'b0;
        for (int c = 1; c < 60 && done_c < 0; c++) begin
            @(posedge clk); #1;
            load_start = 1'b0;
            byte_valid = (i < 8) && (mode == 0 || (mode == 1 && c % 2 == 1) ||
                                     (mode == 2 && $urandom_range(0, 1) == 1));
            byte_in = (i < 8) ? b[i] : 8'($urandom);
            #1;
            if (byte_valid && byte_ready) begin acc[i] = c; i++; end
            if (mem_we) begin
                n_checks++;
                if (byte_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ready_in_write: byte_ready=%b required 0", tag, byte_ready);
                end
                if (wr < 2) begin wc[wr] = c; wa[wr] = mem_a; wd[wr] = mem_wd; end
                wr++;
            end
            if (load_done) begin done_c = c; br_done = byte_ready; end
        end
        byte_valid = 1'b0;
        n_checks++;
        if (wr != 2 || i != 8) begin
            n_fail++;
            $display("FAIL %s write_count: writes=%0d bytes=%0d required 2 and 8", tag, wr, i);
        end
        for (int k = 0; k < 2; k++) begin
            w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            n_checks++;
            if ({wa[k], wd[k]} !== {32'(4*k), w}) begin
                n_fail++;
                $display("FAIL %s write%0d: A=%h WD=%h required A=%h WD=%h", tag, k, wa[k], wd[k], 32'(4*k), w);
            end
            n_checks++;
            if (wc[k] != acc[4*k+3] + 1) begin
                n_fail++;
                $display("FAIL %s write%0d_timing: cycle %0d required %0d", tag, k, wc[k], acc[4*k+3] + 1);
            end
            n_checks++;
            if (mem[k] !== w) begin
                n_fail++;
                $display("FAIL %s mem%0d: %h required %h", tag, k, mem[k], w);
            end
        end
        n_checks++;
        if (done_c != wc[1] + 1 || br_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s load_done: cycle %0d ready=%b required cycle %0d ready 0", tag, done_c, br_done, wc[1] + 1);
        end
        if (mode == 0) begin
            n_checks++;
            if (wc[0] != 5 || wc[1] != 10 || done_c != 11) begin
                n_fail++;
                $display("FAIL %s cycles: we@%0d,%0d done@%0d required 5,10,11", tag, wc[0], wc[1], done_c);
            end
        end
        @(posedge clk); #2;
        n_checks++;
        if ({load_done, byte_ready, mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s after_done: ld/br/we=%b%b%b required 000", tag, load_done, byte_ready, mem_we);
        end
    endtask

    task automatic test_run();
        int          dr_run[10] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
        int          dr_br[10]  = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 0};
        logic [31:0] dr_tg[10]  = '{0, 0, 32'h7, 32'h3C, 0, 32'h100, 0, 0, 32'hFFFF_FFFE, 0};
        logic [31:0] pc_m, tg;
        logic        r, br;
        pc_m = 0;
        @(posedge clk); #1;
        run_en = 1'b1;
        #1;
        n_checks++;
        if ({pc, instr_valid} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL run_idle: pc=%h iv=%b required 0 0", pc, instr_valid);
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            r  = (c < 10) ? (dr_run[c] == 1) : ($urandom_range(0, 9) < 7);
            br = (c < 10) ? (dr_br[c] == 1) : ($urandom_range(0, 4) == 0);
            tg = (c < 10) ? dr_tg[c] : $urandom;
            run_en = r; branch_taken = br; branch_target = tg;
            #1;
            n_checks++;
            if ({pc, instr_valid} !== {pc_m, r}) begin
                n_fail++;
                $display("FAIL run_pc c%0d: pc=%h iv=%b required pc=%h iv=%b", c, pc, instr_valid, pc_m, r);
            end
            if (r) begin
                n_checks++;
                if (instr !== mem[pc_m[5:2]]) begin
                    n_fail++;
                    $display("FAIL run_instr c%0d: %h required %h", c, instr, mem[pc_m[5:2]]);
                end
                pc_m = br ? {tg[31:2], 2'b00} : pc_m + 32'd4;
            end
        end
        run_en = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_restart();
        logic [7:0]  nb[4];
        logic [31:0] w;
        for (int k = 0; k < 4; k++) nb[k] = 8'($urandom);
        w = {nb[3], nb[2], nb[1], nb[0]};
        @(posedge clk); #1;
        load_start = 1'b1; run_en = 1'b0; byte_valid = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b0; byte_valid = 1'b1; byte_in = 8'h11;
        #1;
        n_checks++;
        if ({pc, byte_ready, mem_a} !== {32'h0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL run_abort: pc=%h br=%b a=%h required 0 1 0", pc, byte_ready, mem_a);
        end
        @(posedge clk); #1;
        byte_in = 8'h22;
        @(posedge clk); #1;
        byte_valid = 1'b0; load_start = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_we: mem_we=%b required 0", mem_we);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            load_start = 1'b0; byte_valid = 1'b1; byte_in = nb[k];
            #1;
            n_checks++;
            if ({mem_we, byte_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL restart_byte%0d: we/br=%b%b required 01", k, mem_we, byte_ready);
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        #1;
        n_checks++;
        if ({mem_we, mem_a, mem_wd, byte_ready} !== {1'b1, 32'h0, w, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_write: we=%b A=%h WD=%h br=%b required 1 0 %h 0", mem_we, mem_a, mem_wd, byte_ready, w);
        end
    endtask

    task automatic test_reset_in_write();
        logic [31:0] old;
        @(posedge clk); #1;
        old = mem[1];
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b1; byte_in = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_write_we: mem_we=%b required 0", mem_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({byte_ready, load_done, instr_valid, mem_we, pc, mem_a} !== '0 || mem[1] !== old) begin
            n_fail++;
            $display("FAIL rst_write_state: br/ld/iv/we=%b%b%b%b pc=%h mem1=%h required 0 and mem1=%h",
                     byte_ready, load_done, instr_valid, mem_we, pc, mem[1], old);
        end
    endtask

    initial begin
        logic [7:0] b0[8];
        logic [7:0] br[8];
        b0 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int k = 0; k < 16; k++) mem[k] = 32'hA500_0000 | 32'(k);
        test_reset();
        test_load(b0, 0, "load_basic");
        test_load(b0, 1, "load_gapped");
        test_run();
        for (int k = 0; k < 8; k++) br[k] = 8'($urandom);
        test_load(br, 2, "load_random");
        test_restart();
        test_reset_in_write();
        for (int k = 0; k < 8; k++) br[k] = 8'($urandom);
        test_load(br, 0, "load_after_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
